// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions used by the data-memory access path.
// Holds the funct3 load/store encodings, the memory-access FSM state type
// and small helpers for byte enables, store-lane replication and
// misalignment detection.
package riscv_pkg;

  // Load encodings (funct3)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store encodings (funct3)
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Access size lives in funct3[1:0]; anything other than byte or half is
  // treated as a word access.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] off);
    return ((size == SZ_HALF) && off[0]) ||
           (size[1] && (off != 2'b00));
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size,
                                         input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the store operand across all lanes so the memory only needs
  // the byte enables to pick the right bytes.
  function automatic logic [31:0] store_data(input logic [1:0] size,
                                             input logic [31:0] w);
    case (size)
      SZ_BYTE: return {4{w[7:0]}};
      SZ_HALF: return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage access controller (master) and the
// data memory (slave).
//
// Handshake: the master raises dmem_req together with dmem_we, dmem_addr,
// dmem_be and dmem_wdata and holds all of them stable until the slave
// returns a single-cycle dmem_ack; dmem_rdata is only meaningful in the
// cycle dmem_ack is high. Acks seen while no request is outstanding are
// dropped by the master.
//
// Signals:
//   dmem_req   master->slave  request valid
//   dmem_we    master->slave  write enable
//   dmem_addr  master->slave  word-aligned byte address
//   dmem_be    master->slave  byte enables
//   dmem_wdata master->slave  lane-replicated store data
//   dmem_ack   slave->master  one-cycle completion pulse
//   dmem_rdata slave->master  read word, valid with dmem_ack
interface mem_access_ctrl_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_load_align.sv
// Combinational load alignment: shifts the returned word right by the byte
// offset and sign- or zero-extends according to the load funct3.
//
// Ports:
//   word_i    raw 32-bit word from memory
//   offset_i  byte offset within the word (addr[1:0])
//   funct3_i  load encoding (LB/LH/LW/LBU/LHU)
//   data_o    aligned, extended load result
module mem_load_align
  import riscv_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  assign shifted = word_i >> {offset_i, 3'b000};

  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_LB:   data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_LW:   data_o = shifted;
      F3_LBU:  data_o = {24'h0, shifted[7:0]};
      F3_LHU:  data_o = {16'h0, shifted[15:0]};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller. Turns a load/store in the MEM
// stage into a bus request, stalls the pipeline until the memory acks, and
// returns aligned load data in the DONE cycle. Misaligned halfword/word
// accesses never reach the bus; they pulse misalign_o and flush_W instead.
//
// Optional feature: define MEM_CTRL_TIMEOUT_EN to abort a request that
// has not been acked within TIMEOUT_CYCLES WAIT cycles (bus_err_o and
// flush_W pulse in DONE, load data forced to 0). Without the macro WAIT
// holds until ack and bus_err_o is tied low.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   mem_rd_M/wr_M  load / store in MEM
//   funct3_M       access size and sign
//   addr_M         byte address
//   wdata_M        store operand
//   bus            data-memory bus (master side)
//   rd_data_M      load data to the MEM/WB register
//   stall_o        freezes all pipeline registers
//   flush_W        zeros the MEM/WB register input this edge
//   misalign_o     misaligned-access pulse
//   bus_err_o      timeout pulse
//   state_o        current FSM state (debug)
module mem_access_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_rd_M,
  input  logic                mem_wr_M,
  input  logic [2:0]          funct3_M,
  input  logic [31:0]         addr_M,
  input  logic [31:0]         wdata_M,
  mem_access_ctrl_if.master   bus,
  output logic [31:0]         rd_data_M,
  output logic                stall_o,
  output logic                flush_W,
  output logic                misalign_o,
  output logic                bus_err_o,
  output mem_state_t          state_o
);

  mem_state_t  state_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] rdata_q;
`ifdef MEM_CTRL_TIMEOUT_EN
  logic [31:0] cnt_q;
  logic        err_q;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  logic        op_valid;
  logic        misaligned;
  logic [31:0] load_data;

  assign op_valid   = mem_rd_M | mem_wr_M;
  assign misaligned = is_misaligned(funct3_M[1:0], addr_M[1:0]);
  assign state_o    = state_q;

  mem_load_align u_align (
    .word_i   (rdata_q),
    .offset_i (addr_q[1:0]),
    .funct3_i (funct3_q),
    .data_o   (load_data)
  );

  // IDLE drives the bus straight from the MEM-stage operands so the request
  // goes out in the same cycle; WAIT replays the registered copy.
  always_comb begin
    bus.dmem_req   = 1'b0;
    bus.dmem_we    = 1'b0;
    bus.dmem_addr  = '0;
    bus.dmem_be    = '0;
    bus.dmem_wdata = '0;
    rd_data_M      = '0;
    stall_o        = 1'b0;
    flush_W        = 1'b0;
    misalign_o     = 1'b0;
    bus_err_o      = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          if (misaligned) begin
            misalign_o = 1'b1;
            flush_W    = 1'b1;
          end else begin
            bus.dmem_req   = 1'b1;
            bus.dmem_we    = mem_wr_M;
            bus.dmem_addr  = {addr_M[31:2], 2'b00};
            bus.dmem_be    = byte_en(funct3_M[1:0], addr_M[1:0]);
            bus.dmem_wdata = store_data(funct3_M[1:0], wdata_M);
            stall_o        = 1'b1;
          end
        end
      end
      WAIT: begin
        bus.dmem_req   = 1'b1;
        bus.dmem_we    = we_q;
        bus.dmem_addr  = {addr_q[31:2], 2'b00};
        bus.dmem_be    = be_q;
        bus.dmem_wdata = wdata_q;
        stall_o        = 1'b1;
      end
      DONE: begin
        rd_data_M = we_q ? 32'h0 : load_data;
`ifdef MEM_CTRL_TIMEOUT_EN
        flush_W   = err_q;
        bus_err_o = err_q;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      rdata_q  <= '0;
`ifdef MEM_CTRL_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (op_valid && !misaligned) begin
            addr_q   <= addr_M;
            be_q     <= byte_en(funct3_M[1:0], addr_M[1:0]);
            wdata_q  <= store_data(funct3_M[1:0], wdata_M);
            we_q     <= mem_wr_M;
            funct3_q <= funct3_M;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (bus.dmem_ack) begin
            rdata_q <= bus.dmem_rdata;
            state_q <= DONE;
          end
`ifdef MEM_CTRL_TIMEOUT_EN
          // The counter reaching TIMEOUT_CYCLES-1 here means this is the
          // TIMEOUT_CYCLES-th WAIT cycle without an ack.
          else if (cnt_q == TIMEOUT_CYCLES - 1) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
`endif
        end
        DONE: begin
          state_q <= IDLE;
`ifdef MEM_CTRL_TIMEOUT_EN
          cnt_q   <= '0;
          err_q   <= 1'b0;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus a
// randomized load/store stream against a byte-lane memory model.
module tb_mem_access_ctrl;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd_M, mem_wr_M;
  logic [2:0]  funct3_M;
  logic [31:0] addr_M, wdata_M, rd_data_M;
  logic        stall_o, flush_W, misalign_o, bus_err_o;
  mem_state_t  state_o;

  mem_access_ctrl_if bus ();

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem[16];

  mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_rd_M   (mem_rd_M),
    .mem_wr_M   (mem_wr_M),
    .funct3_M   (funct3_M),
    .addr_M     (addr_M),
    .wdata_M    (wdata_M),
    .bus        (bus),
    .rd_data_M  (rd_data_M),
    .stall_o    (stall_o),
    .flush_W    (flush_W),
    .misalign_o (misalign_o),
    .bus_err_o  (bus_err_o),
    .state_o    (state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model: byte-lane view of each access
  function automatic int nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    be = '0;
    for (int k = 0; k < nbytes(f3); k++) be[int'(off) + k] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] v;
    for (int k = 0; k < 4; k++) v[8*k +: 8] = wd[8*(k % nbytes(f3)) +: 8];
    return v;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0] v;
    int nb;
    nb = nbytes(f3);
    v = '0;
    for (int k = 0; k < nb; k++) v[8*k +: 8] = word[8*(int'(off) + k) +: 8];
    if (!f3[2] && nb < 4 && v[8*nb-1])
      for (int k = nb; k < 4; k++) v[8*k +: 8] = 8'hFF;
    return v;
  endfunction

  // driver: one full access starting in IDLE; delay = WAIT cycles before ack
  task automatic do_access(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rword,
                           input int delay, input string tag);
    logic [3:0]  ebe;
    logic [31:0] ewd, eaddr, got;
    mem_rd_M = !wr; mem_wr_M = wr; funct3_M = f3; addr_M = addr; wdata_M = wd;
    bus.dmem_ack = 1'b0;
    #1;
    if ((int'(addr[1:0]) % nbytes(f3)) != 0) begin
      total_cnt++;
      if ({bus.dmem_req, stall_o, misalign_o, flush_W} !== 4'b0011)
        $display("FAIL %s misalign_ctl: got req/stall/mis/flush=%b expected 0011", tag,
                 {bus.dmem_req, stall_o, misalign_o, flush_W});
      else pass_cnt++;
      tick();
      mem_rd_M = 1'b0; mem_wr_M = 1'b0;
      #1;
      total_cnt++;
      if ({state_o, misalign_o, flush_W, stall_o} !== {IDLE, 3'b000})
        $display("FAIL %s misalign_after: got state=%0d mis/flush/stall=%b expected IDLE 000",
                 tag, state_o, {misalign_o, flush_W, stall_o});
      else pass_cnt++;
      return;
    end
    ebe = exp_be(f3, addr[1:0]);
    ewd = exp_wdata(f3, wd);
    eaddr = {addr[31:2], 2'b00};
    exp_q.push_back(wr ? 32'h0 : ref_load(f3, addr[1:0], rword));
    // IDLE cycle: request issued combinationally
    total_cnt++;
    if ({bus.dmem_req, stall_o, bus.dmem_we, misalign_o, flush_W, rd_data_M} !==
        {3'b11, wr, 2'b00, 32'h0})
      $display("FAIL %s idle_ctl: got req/stall/we/mis/flush=%b rd=%h expected 11%b00 0",
               tag, {bus.dmem_req, stall_o, bus.dmem_we, misalign_o, flush_W}, wr, rd_data_M);
    else pass_cnt++;
    total_cnt++;
    if ({bus.dmem_addr, bus.dmem_be} !== {eaddr, ebe})
      $display("FAIL %s idle_addr_be: got %h/%b expected %h/%b", tag,
               bus.dmem_addr, bus.dmem_be, eaddr, ebe);
    else pass_cnt++;
    if (wr) begin
      total_cnt++;
      if (bus.dmem_wdata !== ewd)
        $display("FAIL %s idle_wdata: got %h expected %h", tag, bus.dmem_wdata, ewd);
      else pass_cnt++;
    end
    tick();
    // WAIT: scramble MEM-stage operands, bus must hold the captured request
    addr_M = $urandom; wdata_M = $urandom;
    for (int i = 0; i < delay; i++) begin
      #1;
      total_cnt++;
      if ({bus.dmem_req, stall_o, bus.dmem_we, bus.dmem_addr, bus.dmem_be} !==
          {2'b11, wr, eaddr, ebe})
        $display("FAIL %s wait_hold: got req/stall=%b addr=%h be=%b expected 11 %h %b", tag,
                 {bus.dmem_req, stall_o}, bus.dmem_addr, bus.dmem_be, eaddr, ebe);
      else pass_cnt++;
      tick();
    end
    bus.dmem_ack = 1'b1; bus.dmem_rdata = rword;
    #1;
    total_cnt++;
    if ({bus.dmem_req, stall_o, bus.dmem_addr, bus.dmem_be} !== {2'b11, eaddr, ebe})
      $display("FAIL %s wait_ack: got req/stall=%b addr=%h be=%b expected 11 %h %b", tag,
               {bus.dmem_req, stall_o}, bus.dmem_addr, bus.dmem_be, eaddr, ebe);
    else pass_cnt++;
    if (wr) begin
      total_cnt++;
      if (bus.dmem_wdata !== ewd)
        $display("FAIL %s wait_wdata: got %h expected %h", tag, bus.dmem_wdata, ewd);
      else pass_cnt++;
    end
    tick();
    bus.dmem_ack = 1'b0; bus.dmem_rdata = $urandom;
    #1;
    // DONE
    got = exp_q.pop_front();
    total_cnt++;
    if ({state_o, bus.dmem_req, stall_o, flush_W, bus_err_o, misalign_o} !== {DONE, 5'b00000})
      $display("FAIL %s done_ctl: got state=%0d req/stall/flush/err/mis=%b expected DONE 00000",
               tag, state_o, {bus.dmem_req, stall_o, flush_W, bus_err_o, misalign_o});
    else pass_cnt++;
    total_cnt++;
    if (rd_data_M !== got)
      $display("FAIL %s done_rdata: got %h expected %h", tag, rd_data_M, got);
    else pass_cnt++;
    tick();
  endtask

  task automatic go_idle();
    mem_rd_M = 1'b0; mem_wr_M = 1'b0; bus.dmem_ack = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_rd_M = 1'b0; mem_wr_M = 1'b0; funct3_M = '0; addr_M = '0; wdata_M = '0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({state_o, bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_be, bus.dmem_wdata,
         rd_data_M, stall_o, flush_W, misalign_o, bus_err_o} !== {IDLE, 106'h0})
      $display("FAIL reset_outputs: got state=%0d req=%b addr=%h be=%b rd=%h stall=%b expected all 0",
               state_o, bus.dmem_req, bus.dmem_addr, bus.dmem_be, rd_data_M, stall_o);
    else pass_cnt++;
  endtask

  task automatic test_lw_basic();
    do_access(1'b0, F3_LW, 32'h100, 32'h0, 32'hDEADBEEF, 0, "lw_basic");
    go_idle();
  endtask

  task automatic test_byte_loads();
    do_access(1'b0, F3_LB, 32'h103, 32'h0, 32'h80FFFFFF, 1, "lb_signed");
    do_access(1'b0, F3_LBU, 32'h103, 32'h0, 32'h80FFFFFF, 0, "lbu");
    do_access(1'b0, F3_LH, 32'h102, 32'h0, 32'h8001_1234, 2, "lh_signed");
    do_access(1'b0, F3_LHU, 32'h102, 32'h0, 32'h8001_1234, 0, "lhu");
    go_idle();
  endtask

  task automatic test_store_half();
    do_access(1'b1, F3_SH, 32'h202, 32'h1234ABCD, 32'h5555AAAA, 0, "sh");
    do_access(1'b1, F3_SB, 32'h201, 32'h000000A5, 32'h0, 1, "sb");
    do_access(1'b1, F3_SW, 32'h204, 32'hCAFEF00D, 32'h0, 0, "sw");
    go_idle();
  endtask

  task automatic test_misalign();
    do_access(1'b0, F3_LW, 32'h101, 32'h0, 32'h0, 0, "lw_mis");
    do_access(1'b1, F3_SH, 32'h203, 32'h1111, 32'h0, 0, "sh_mis");
    do_access(1'b0, F3_LHU, 32'h105, 32'h0, 32'h0, 0, "lhu_mis");
    go_idle();
  endtask

  task automatic test_back_to_back();
    do_access(1'b0, F3_LW, 32'h300, 32'h0, 32'h01020304, 0, "b2b_0");
    do_access(1'b1, F3_SW, 32'h304, 32'h0BADBEEF, 32'h0, 0, "b2b_1");
    do_access(1'b0, F3_LB, 32'h301, 32'h0, 32'h0000F700, 0, "b2b_2");
    go_idle();
  endtask

  task automatic test_idle_ack();
    go_idle();
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hFFFFFFFF;
    tick();
    bus.dmem_ack = 1'b0;
    #1;
    total_cnt++;
    if ({state_o, bus.dmem_req, stall_o, rd_data_M} !== {IDLE, 2'b00, 32'h0})
      $display("FAIL idle_ack: got state=%0d req/stall=%b rd=%h expected IDLE 00 0",
               state_o, {bus.dmem_req, stall_o}, rd_data_M);
    else pass_cnt++;
  endtask

  task automatic test_reset_in_wait();
    mem_rd_M = 1'b1; mem_wr_M = 1'b0; funct3_M = F3_LW; addr_M = 32'h400;
    bus.dmem_ack = 1'b0;
    tick();
    #1;
    total_cnt++;
    if (state_o !== WAIT)
      $display("FAIL rst_wait_enter: got state=%0d expected WAIT", state_o);
    else pass_cnt++;
    rst = 1'b1; mem_rd_M = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({state_o, bus.dmem_req, stall_o} !== {IDLE, 2'b00})
      $display("FAIL rst_wait_abort: got state=%0d req/stall=%b expected IDLE 00",
               state_o, {bus.dmem_req, stall_o});
    else pass_cnt++;
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h12345678;
    tick();
    bus.dmem_ack = 1'b0;
    #1;
    total_cnt++;
    if ({state_o, bus.dmem_req, stall_o, rd_data_M} !== {IDLE, 2'b00, 32'h0})
      $display("FAIL rst_wait_late_ack: got state=%0d req/stall=%b rd=%h expected IDLE 00 0",
               state_o, {bus.dmem_req, stall_o}, rd_data_M);
    else pass_cnt++;
    do_access(1'b0, F3_LW, 32'h404, 32'h0, 32'h600DF00D, 0, "after_rst");
    go_idle();
  endtask

`ifdef MEM_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    mem_rd_M = 1'b1; mem_wr_M = 1'b0; funct3_M = F3_LW; addr_M = 32'h500;
    bus.dmem_ack = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      total_cnt++;
      if ({state_o, stall_o, bus_err_o} !== {WAIT, 2'b10})
        $display("FAIL timeout_wait: got state=%0d stall/err=%b expected WAIT 10",
                 state_o, {stall_o, bus_err_o});
      else pass_cnt++;
      tick();
    end
    #1;
    total_cnt++;
    if ({state_o, bus_err_o, flush_W, stall_o, bus.dmem_req, rd_data_M} !== {DONE, 4'b1100, 32'h0})
      $display("FAIL timeout_done: got state=%0d err/flush/stall/req=%b rd=%h expected DONE 1100 0",
               state_o, {bus_err_o, flush_W, stall_o, bus.dmem_req}, rd_data_M);
    else pass_cnt++;
    mem_rd_M = 1'b0;
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hABABABAB;
    tick();
    bus.dmem_ack = 1'b0;
    #1;
    total_cnt++;
    if ({state_o, bus_err_o, flush_W, bus.dmem_req, rd_data_M} !== {IDLE, 3'b000, 32'h0})
      $display("FAIL timeout_late_ack: got state=%0d err/flush/req=%b rd=%h expected IDLE 000 0",
               state_o, {bus_err_o, flush_W, bus.dmem_req}, rd_data_M);
    else pass_cnt++;
  endtask
`else
  task automatic test_timeout();
    mem_rd_M = 1'b1; mem_wr_M = 1'b0; funct3_M = F3_LW; addr_M = 32'h500;
    bus.dmem_ack = 1'b0;
    tick();
    repeat (30) tick();
    #1;
    total_cnt++;
    if ({state_o, stall_o, bus.dmem_req, bus_err_o, flush_W} !== {WAIT, 4'b1100})
      $display("FAIL hold_wait: got state=%0d stall/req/err/flush=%b expected WAIT 1100",
               state_o, {stall_o, bus.dmem_req, bus_err_o, flush_W});
    else pass_cnt++;
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h0F0F0F0F;
    tick();
    bus.dmem_ack = 1'b0; mem_rd_M = 1'b0;
    #1;
    total_cnt++;
    if ({state_o, rd_data_M, bus_err_o} !== {DONE, 32'h0F0F0F0F, 1'b0})
      $display("FAIL hold_done: got state=%0d rd=%h err=%b expected DONE 0f0f0f0f 0",
               state_o, rd_data_M, bus_err_o);
    else pass_cnt++;
    tick();
  endtask
`endif

  task automatic test_random();
    logic [2:0] ld_ops[5];
    logic [2:0] st_ops[3];
    logic [2:0] f3;
    logic [31:0] addr, wd, ewd;
    logic [3:0] ebe;
    bit wr;
    int idx;
    ld_ops = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    st_ops = '{F3_SB, F3_SH, F3_SW};
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    for (int n = 0; n < 60; n++) begin
      wr = 1'($urandom_range(0, 1));
      f3 = wr ? st_ops[$urandom_range(0, 2)] : ld_ops[$urandom_range(0, 4)];
      idx = $urandom_range(0, 15);
      addr = 32'h1000 + 32'(idx * 4) + 32'($urandom_range(0, 3));
      wd = $urandom;
      do_access(wr, f3, addr, wd, wr ? 32'($urandom) : mem[idx],
                $urandom_range(0, 3), "rand");
      if (wr && (int'(addr[1:0]) % nbytes(f3)) == 0) begin
        ebe = exp_be(f3, addr[1:0]);
        ewd = exp_wdata(f3, wd);
        for (int k = 0; k < 4; k++) if (ebe[k]) mem[idx][8*k +: 8] = ewd[8*k +: 8];
      end
      if ($urandom_range(0, 3) == 0) begin
        mem_rd_M = 1'b0; mem_wr_M = 1'b0;
        bus.dmem_ack = 1'($urandom_range(0, 1)); bus.dmem_rdata = $urandom;
        #1;
        total_cnt++;
        if ({bus.dmem_req, stall_o, rd_data_M} !== {2'b00, 32'h0})
          $display("FAIL rand_idle: got req/stall=%b rd=%h expected 00 0",
                   {bus.dmem_req, stall_o}, rd_data_M);
        else pass_cnt++;
        tick();
        bus.dmem_ack = 1'b0;
      end
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_lw_basic();
    test_byte_loads();
    test_store_half();
    test_misalign();
    test_back_to_back();
    test_idle_ack();
    test_reset_in_wait();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, giving the WAIT cycles before a bus-error abort (used only with MEM_CTRL_TIMEOUT_EN).
REQ-002 The block SHALL have these ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, synchronous, active-high
mem_rd_M  in  1  load in MEM stage
mem_wr_M  in  1  store in MEM stage
funct3_M  in  3  access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
addr_M  in  32  byte address (ALU result)
wdata_M  in  32  store data (rs2)
dmem_req  out  1  data-memory request
dmem_we  out  1  write enable
dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_ack  in  1  one-cycle completion pulse
dmem_rdata  in  32  read word, valid with dmem_ack
rd_data_M  out  32  aligned, extended load data to MEM/WB register
stall_o  out  1  freezes all pipeline registers
flush_W  out  1  zeros MEM/WB register input this edge
misalign_o  out  1  misaligned-access pulse
bus_err_o  out  1  timeout pulse

Function
REQ-003 The block SHALL implement FSM states IDLE, WAIT, DONE.
REQ-004 In IDLE, an aligned mem_rd_M or mem_wr_M SHALL assert dmem_req and stall_o combinationally, register addr/be/wdata/we/funct3, and move to WAIT.
REQ-005 In WAIT, dmem_req and stall_o SHALL stay 1 with outputs driven from the registered copy; on dmem_ack the block SHALL latch dmem_rdata and move to DONE.
REQ-006 In DONE, stall_o SHALL be 0, rd_data_M SHALL come from the latched word, and the next state SHALL be IDLE unconditionally.
REQ-007 Minimum access occupancy SHALL be 3 cycles in MEM (IDLE, WAIT with ack, DONE); back-to-back accesses SHALL be issued in the IDLE cycle following DONE.
REQ-008 dmem_be SHALL be 0001<<addr[1:0] for bytes, 0011<<addr[1:0] for halves, 1111 for words.
REQ-009 dmem_wdata SHALL replicate byte x4 for SB, halfword x2 for SH, and pass the word for SW.
REQ-010 Load data SHALL be shifted right 8*addr[1:0], then sign-extended (LB/LH) or zero-extended (LBU/LHU); LW passes unchanged; stores return rd_data_M=0.
REQ-011 Halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL issue no request, pulse misalign_o and flush_W for one cycle, keep stall_o 0, and remain in IDLE.
REQ-012 dmem_ack in IDLE or DONE SHALL be ignored.
REQ-013 No mem op in IDLE SHALL yield stall_o=0, dmem_req=0, rd_data_M=0.

Reset
REQ-014 On rst the FSM SHALL go to IDLE; the latched data, registered request fields and timeout counter SHALL clear to 0.
REQ-015 After reset every output SHALL be 0 until a new mem op appears.
REQ-016 rst during WAIT SHALL abandon the access, drop dmem_req the next cycle, and ignore a later ack.

Configuration
REQ-017 With MEM_CTRL_TIMEOUT_EN defined, a counter SHALL increment each WAIT cycle without ack; on reaching TIMEOUT_CYCLES the block SHALL go to DONE with data 0 and pulse bus_err_o and flush_W in DONE.
REQ-018 Without MEM_CTRL_TIMEOUT_EN, WAIT SHALL hold indefinitely and bus_err_o SHALL be tied 0.

Structure
REQ-019 The shared package riscv_pkg SHALL hold the funct3 load/store encodings and the mem_state_t enum.
REQ-020 Load alignment/extension SHALL be the combinational sub-module mem_load_align.

Verification
REQ-021 LW addr=0x100, ack on the 1st WAIT cycle, rdata=0xDEADBEEF -> stall_o high 2 cycles, rd_data_M=0xDEADBEEF in DONE.
REQ-022 LB addr=0x103, rdata=0x80FF_FFFF -> be=1000, rd_data_M=0xFFFFFF80; LBU -> 0x00000080.
REQ-023 SH addr=0x202, wdata=0x1234ABCD -> be=1100, dmem_wdata=0xABCDABCD, dmem_we=1.
REQ-024 LW addr=0x101 -> no dmem_req, misalign_o=1 and flush_W=1 for one cycle, stall_o=0.
REQ-025 With TIMEOUT_CYCLES=4 and no ack -> bus_err_o and flush_W pulse in DONE after 4 WAIT cycles, then IDLE; a late ack is ignored.
REQ-026 rst asserted during WAIT -> next cycle IDLE, dmem_req=0, stall_o=0.
